// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   Front end of the single-clock MIPS pipeline, sitting directly upstream of
//   INST_mem. It runs in two phases:
//     LOAD : accepts a streamed program over a valid/ready handshake and writes
//            it word by word into INST_mem through its write port.
//     RUN  : owns the PC, drives INST_mem read_address and registers the
//            returned instruction into the IF/ID pipeline register. Supports
//            stall, branch/jump redirect with flush, and halts on syscall.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, adds saturating perf counters perf_fetched / perf_stalls.
//
// Parameters
//   RESET_PC    PC value on reset and on entering RUN.
//   MEM_WORDS   INST_mem depth in words; caps the load counter.
//   HALT_INSTR  Encoding that stops fetch (syscall).
//
// Ports
//   clk, reset_n                    clock, async active-low reset
//   load_valid/load_data/load_last  program stream in
//   load_ready                      stream accept (high while loading)
//   load_err                        sticky: a word arrived beyond MEM_WORDS
//   imem_write_address/instruc_data INST_mem write port
//   imem_read_address               INST_mem read address (= pc)
//   imem_instruction                INST_mem combinational read data
//   stall                           hold pc and IF/ID
//   redirect/redirect_target        branch/jump redirect, flushes IF/ID
//   if_id_instr/if_id_pc4/if_id_valid  IF/ID pipeline register
//   halted                          high once fetch has stopped on syscall
//   perf_fetched/perf_stalls        (FETCH_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS  = 8192,
    parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        load_err,
    output logic [31:0] imem_write_address,
    output logic [31:0] imem_instruc_data,
    output logic [31:0] imem_read_address,
    input  logic [31:0] imem_instruction,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
`endif
);

    localparam int unsigned XLEN  = 32;
    // Counter must be able to hold MEM_WORDS itself (the "memory full" value).
    localparam int unsigned CNT_W = $clog2(MEM_WORDS + 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [CNT_W-1:0]  cnt;

    logic              accept_c;
    logic              room_c;
    logic              fetch_c;
    logic              is_halt_c;
    logic [XLEN-1:0]   pc_plus4_c;
    logic [XLEN-1:0]   target_c;
    logic [XLEN-1:0]   wr_addr_c;
    logic              unused_target_lsbs;

    // Handshake, capacity and fetch qualifiers for the current cycle.
    always_comb begin
        accept_c   = 1'b0;
        room_c     = 1'b0;
        fetch_c    = 1'b0;
        is_halt_c  = 1'b0;
        pc_plus4_c = pc + XLEN'(4);
        target_c   = {redirect_target[XLEN-1:2], 2'b00};
        wr_addr_c  = XLEN'({cnt, 2'b00});

        accept_c  = (state == S_LOAD) && load_valid && load_ready;
        room_c    = (cnt < CNT_W'(MEM_WORDS));
        // Redirect beats stall; neither lets a new word into IF/ID.
        fetch_c   = (state == S_RUN) && !redirect && !stall;
        is_halt_c = (imem_instruction == HALT_INSTR);
    end

    // Target is word aligned by construction; its byte-offset bits are dropped.
    assign unused_target_lsbs = ^redirect_target[1:0];

    // The PC register doubles as the INST_mem read address.
    assign imem_read_address = pc;

    // Load/run/halt control with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= S_LOAD;
            pc                 <= RESET_PC;
            cnt                <= '0;
            load_ready         <= 1'b0;
            load_err           <= 1'b0;
            imem_write_address <= '0;
            imem_instruc_data  <= '0;
            if_id_instr        <= '0;
            if_id_pc4          <= '0;
            if_id_valid        <= 1'b0;
            halted             <= 1'b0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    load_ready  <= 1'b1;
                    pc          <= RESET_PC;
                    if_id_valid <= 1'b0;
                    if (accept_c) begin
                        // Words past the end are swallowed, not back-pressured.
                        if (room_c) begin
                            imem_write_address <= wr_addr_c;
                            imem_instruc_data  <= load_data;
                            cnt                <= cnt + CNT_W'(1);
                        end else begin
                            load_err <= 1'b1;
                        end
                        if (load_last) begin
                            state      <= S_RUN;
                            load_ready <= 1'b0;
                        end
                    end
                end

                S_RUN: begin
                    // Write port keeps its last pair; INST_mem rewrites it harmlessly.
                    if (redirect) begin
                        pc          <= target_c;
                        if_id_valid <= 1'b0;
                    end else if (!stall) begin
                        pc          <= pc_plus4_c;
                        if_id_instr <= imem_instruction;
                        if_id_pc4   <= pc_plus4_c;
                        if_id_valid <= 1'b1;
                        // Syscall is still handed to decode, then fetch stops.
                        if (is_halt_c) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                    end
                end

                S_HALT: begin
                    if_id_valid <= 1'b0;
                    halted      <= 1'b1;
                end

                default: begin
                    state <= S_LOAD;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating fetch and stall event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (fetch_c && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + XLEN'(1);
            end
            if ((state == S_RUN) && stall && !redirect && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//   Scoreboard bench for instruction_fetch. A small INST_mem stand-in is driven
//   by the DUT write port; a program-level reference model predicts the state
//   after every clock edge and queues it; a monitor compares after each edge.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    localparam int unsigned MW    = 8;
    localparam int unsigned IDX_W = 3;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] HALT  = 32'h0000_000C;

    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_err;
    logic [31:0] imem_write_address;
    logic [31:0] imem_instruc_data;
    logic [31:0] imem_read_address;
    logic [31:0] imem_instruction;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;
`endif

    instruction_fetch #(
        .RESET_PC   (RPC),
        .MEM_WORDS  (MW),
        .HALT_INSTR (HALT)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .load_valid         (load_valid),
        .load_data          (load_data),
        .load_last          (load_last),
        .load_ready         (load_ready),
        .load_err           (load_err),
        .imem_write_address (imem_write_address),
        .imem_instruc_data  (imem_instruc_data),
        .imem_read_address  (imem_read_address),
        .imem_instruction   (imem_instruction),
        .stall              (stall),
        .redirect           (redirect),
        .redirect_target    (redirect_target),
        .if_id_instr        (if_id_instr),
        .if_id_pc4          (if_id_pc4),
        .if_id_valid        (if_id_valid),
        .halted             (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched       (perf_fetched),
        .perf_stalls        (perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    // INST_mem stand-in: clocked write of the presented pair, combinational read.
    logic [31:0] imem [MW];
    always @(posedge clk) imem[imem_write_address[IDX_W+1:2]] <= imem_instruc_data;
    assign imem_instruction = imem[imem_read_address[IDX_W+1:2]];

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc, instr, pc4, wa, wd, fetched, stalls;
        logic        valid, halted, ready, err;
    } snap_t;

    snap_t       exp_q[$];
    logic [31:0] ref_mem [MW];
    int          m_mode;
    int unsigned m_cnt;
    logic [31:0] m_pc, m_instr, m_pc4, m_wa, m_wd, m_fetched, m_stalls;
    logic        m_valid, m_halted, m_ready, m_err;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_LOAD; m_cnt = 0; m_pc = RPC;
        m_instr = '0; m_pc4 = '0; m_wa = '0; m_wd = '0;
        m_fetched = '0; m_stalls = '0;
        m_valid = 1'b0; m_halted = 1'b0; m_ready = 1'b0; m_err = 1'b0;
    endtask

    // Predict the effect of the coming rising edge from the inputs now applied.
    task automatic model_step();
        snap_t s;
        if (m_mode == M_LOAD) begin
            if (load_valid && m_ready) begin
                if (m_cnt < MW) begin
                    ref_mem[m_cnt] = load_data;
                    m_wa = m_cnt * 4;
                    m_wd = load_data;
                    m_cnt++;
                end else begin
                    m_err = 1'b1;
                end
                if (load_last) m_mode = M_RUN;
            end
            m_ready = (m_mode == M_LOAD);
        end else if (m_mode == M_RUN) begin
            if (redirect) begin
                m_pc    = redirect_target & 32'hFFFF_FFFC;
                m_valid = 1'b0;
            end else if (stall) begin
                if (m_stalls != 32'hFFFF_FFFF) m_stalls++;
            end else begin
                m_instr = ref_mem[(m_pc / 4) % MW];
                m_pc4   = m_pc + 32'd4;
                m_pc    = m_pc + 32'd4;
                m_valid = 1'b1;
                if (m_fetched != 32'hFFFF_FFFF) m_fetched++;
                if (m_instr == HALT) begin
                    m_mode   = M_HALT;
                    m_halted = 1'b1;
                end
            end
        end else begin
            m_valid = 1'b0;
        end
        s.pc = m_pc; s.instr = m_instr; s.pc4 = m_pc4; s.wa = m_wa; s.wd = m_wd;
        s.fetched = m_fetched; s.stalls = m_stalls;
        s.valid = m_valid; s.halted = m_halted; s.ready = m_ready; s.err = m_err;
        exp_q.push_back(s);
    endtask

    // ---------------- monitor ----------------
    initial begin
        snap_t s;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk("pc",          imem_read_address,   s.pc);
                chk("if_id_instr", if_id_instr,         s.instr);
                chk("if_id_pc4",   if_id_pc4,           s.pc4);
                chk("if_id_valid", 32'(if_id_valid),    32'(s.valid));
                chk("halted",      32'(halted),         32'(s.halted));
                chk("load_ready",  32'(load_ready),     32'(s.ready));
                chk("load_err",    32'(load_err),       32'(s.err));
                chk("wr_addr",     imem_write_address,  s.wa);
                chk("wr_data",     imem_instruc_data,   s.wd);
`ifdef FETCH_PERF_CNT_EN
                chk("perf_fetched", perf_fetched, s.fetched);
                chk("perf_stalls",  perf_stalls,  s.stalls);
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic check_reset_outputs();
        chk("rst_load_ready", 32'(load_ready),  32'd0);
        chk("rst_load_err",   32'(load_err),    32'd0);
        chk("rst_wr_addr",    imem_write_address, 32'd0);
        chk("rst_wr_data",    imem_instruc_data,  32'd0);
        chk("rst_rd_addr",    imem_read_address,  RPC);
        chk("rst_instr",      if_id_instr,        32'd0);
        chk("rst_pc4",        if_id_pc4,          32'd0);
        chk("rst_valid",      32'(if_id_valid),   32'd0);
        chk("rst_halted",     32'(halted),        32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_stalls",  perf_stalls,  32'd0);
`endif
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        load_valid = 1'b0; load_last = 1'b0; stall = 1'b0; redirect = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        model_step();
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] tgt);
        @(negedge clk);
        load_valid = 1'($urandom_range(0, 1));
        load_last = 1'($urandom_range(0, 1));
        load_data = $urandom;
        stall = st; redirect = rd; redirect_target = tgt;
        model_step();
    endtask

    task automatic load_program(input logic [31:0] words[$], input bit gaps);
        int i = 0;
        int guard = 0;
        logic acc;
        while (i < words.size()) begin
            @(negedge clk);
            load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_data  = load_valid ? words[i] : $urandom;
            load_last  = load_valid ? (i == words.size() - 1) : 1'($urandom_range(0, 1));
            stall = 1'($urandom_range(0, 1));
            redirect = 1'($urandom_range(0, 1));
            redirect_target = $urandom;
            acc = load_valid && m_ready;
            model_step();
            if (acc) i++;
            guard++;
            if (guard > 400) begin
                checks++; errors++;
                $display("FAIL load_timeout: accepted %0d of %0d words", i, words.size());
                break;
            end
        end
    endtask

    task automatic run_random(input int n, input int stall_pct, input int redir_pct);
        logic [31:0] tgt;
        repeat (n) begin
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 127));
            drive(($urandom_range(0, 99) < stall_pct), ($urandom_range(0, 99) < redir_pct), tgt);
        end
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w = $urandom;
        if (w == HALT) w = w ^ 32'h1;
        return w;
    endfunction

    initial begin
        logic [31:0] prog[$];
        int n;

        reset_n = 1'b0;
        load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        for (int i = 0; i < int'(MW); i++) begin
            imem[i] = '0;
            ref_mem[i] = '0;
        end
        #1;
        check_reset_outputs();

        // Three-word program, stall at pc=8, redirect with simultaneous stall.
        do_reset();
        prog = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003};
        load_program(prog, 1'b0);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h0000_0043);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);

        // PC wrap modulo 2^32 via a redirect near the top of the address space.
        drive(1'b0, 1'b1, 32'hFFFF_FFFE);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);

        // Syscall at pc=4 halts fetch; later redirect/stall are ignored.
        do_reset();
        prog = '{32'h1111_1111, HALT, 32'h3333_3333};
        load_program(prog, 1'b0);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b0, 32'h0);
        drive(1'b0, 1'b1, 32'h0000_0020);
        drive(1'b1, 1'b1, 32'h0000_0008);
        drive(1'b0, 1'b0, 32'h0);

        // Overflow: MW+2 words streamed; extras dropped, load_err raised.
        do_reset();
        prog.delete();
        for (int i = 0; i < int'(MW) + 2; i++) prog.push_back(rand_word());
        load_program(prog, 1'b0);
        run_random(12, 20, 10);

        // Randomised episodes, each starting with a reset in the middle of activity.
        for (int ep = 0; ep < 30; ep++) begin
            do_reset();
            n = $urandom_range(2, int'(MW) + 3);
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back(rand_word());
            if ($urandom_range(0, 2) == 0) prog[$urandom_range(0, n - 1)] = HALT;
            load_program(prog, 1'b1);
            run_random(40, 25, 12);
        end

        // Mid-run reset with nothing else after it but a short run.
        do_reset();
        prog = '{32'h0BAD_F00D, 32'h1234_5678};
        load_program(prog, 1'b1);
        run_random(6, 0, 0);

        @(negedge clk);
        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
